// File: rtl/ctrl_decode_queue.sv
// Control/config packet decoder with entry-time error checking, a DEPTH-entry
// command FIFO, per-unit gated dispatch and host-visible sticky error status.
module ctrl_decode_queue #(
    parameter int NUM_UNITS = 4,
    parameter int ADDR_W    = 4,
    parameter int SIZE_W    = 3,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 8,
    parameter int DROP_ERR  = 1,
    localparam int UNIT_W   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int OCC_W    = PTR_W + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [UNIT_W+3:0]          in_ctrl,
    input  logic [ADDR_W+SIZE_W:0]     in_config,
    input  logic [NUM_UNITS-1:0]       unit_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [UNIT_W-1:0]          out_unit_id,
    output logic [1:0]                 out_op,
    output logic [1:0]                 out_comp,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [SIZE_W-1:0]          out_size,
    output logic [1:0]                 out_err,
    input  logic                       err_clr,
    output logic [1:0]                 err_sticky,
    output logic [CNT_W-1:0]           err_count,
    output logic [OCC_W-1:0]           occupancy
);

    localparam int ENT_W = UNIT_W + 4 + ADDR_W + SIZE_W + 2;
    localparam logic [1:0] OP_NOP     = 2'd0;
    localparam logic [1:0] OP_LOAD    = 2'd1;
    localparam logic [1:0] OP_STORE   = 2'd2;
    localparam logic [1:0] OP_COMPUTE = 2'd3;

    logic [UNIT_W-1:0] w_unit_id;
    logic [1:0]        w_op;
    logic [1:0]        w_comp;
    logic [ADDR_W-1:0] w_addr;
    logic              w_vld;
    logic [SIZE_W-1:0] w_size;
    logic [1:0]        w_err;
    logic [ENT_W-1:0]  w_entry;
    logic [ENT_W-1:0]  w_head;
    logic              w_empty;
    logic              w_unit_rdy;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_err_evt;

    logic [ENT_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [OCC_W-1:0]  r_count;
    logic [1:0]        r_err_sticky;
    logic [CNT_W-1:0]  r_err_count;

    assign w_unit_id = in_ctrl[UNIT_W+3:4];
    assign w_op      = in_ctrl[3:2];
    assign w_comp    = in_ctrl[1:0];
    assign w_addr    = in_config[ADDR_W+SIZE_W:SIZE_W+1];
    assign w_vld     = in_config[SIZE_W];
    assign w_size    = in_config[SIZE_W-1:0];

    // Error classification of the incoming packet, highest priority first
    always_comb begin
        w_err = 2'b00;
        if (32'(w_unit_id) >= NUM_UNITS) begin
            w_err = 2'b10;
        end else if (((w_op == OP_NOP) && (in_config != {(ADDR_W+SIZE_W+1){1'b0}})) ||
                     ((w_op == OP_COMPUTE) && !w_vld)) begin
            w_err = 2'b01;
        end else if (((w_op == OP_LOAD) || (w_op == OP_STORE)) &&
                     (w_size == {SIZE_W{1'b0}})) begin
            w_err = 2'b11;
        end else begin
            w_err = 2'b00;
        end
    end

    assign w_entry   = {w_unit_id, w_op, w_comp, w_addr, w_size, w_err};
    assign in_ready  = !rst && (r_count != OCC_W'(DEPTH));
    assign w_accept  = in_valid && in_ready;
    assign w_err_evt = w_accept && (w_err != 2'b00);
    assign w_push    = w_accept && ((DROP_ERR == 0) || (w_err == 2'b00));

    assign w_empty = (r_count == {OCC_W{1'b0}});
    assign w_head  = w_empty ? {ENT_W{1'b0}} : r_mem[r_rptr];
    assign {out_unit_id, out_op, out_comp, out_addr, out_size, out_err} = w_head;

    // Readiness of the unit addressed by the head entry; out-of-range ids never match
    always_comb begin
        w_unit_rdy = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_unit_rdy = w_unit_rdy | (unit_ready[i] & (32'(out_unit_id) == i));
        end
    end

    // Errored heads bypass unit gating so they can never wedge the queue
    assign out_valid = !w_empty && ((out_err != 2'b00) || w_unit_rdy);
    assign w_pop     = out_valid && out_ready;
    assign occupancy = r_count;

    // FIFO storage, pointers and fill level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {OCC_W{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_entry;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky first-error code and saturating error counter; a coincident
    // clear and new error leaves the new error as the only one recorded
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sticky <= 2'b00;
            r_err_count  <= {CNT_W{1'b0}};
        end else if (err_clr) begin
            r_err_sticky <= w_err_evt ? w_err : 2'b00;
            r_err_count  <= w_err_evt ? CNT_W'(1) : {CNT_W{1'b0}};
        end else if (w_err_evt) begin
            if (r_err_count != {CNT_W{1'b1}}) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
            if (r_err_sticky == 2'b00) begin
                r_err_sticky <= w_err;
            end
        end
    end

    assign err_sticky = r_err_sticky;
    assign err_count  = r_err_count;

`ifndef SYNTHESIS
    // Simulation trace of every accepted errored packet
    always_ff @(posedge clk) begin
        if (!rst && w_err_evt) begin
            $display("ctrl_decode_queue: errored packet accepted, code=%b", w_err);
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_decode_queue.sv
// Scoreboard bench: two configurations (drop vs keep errors, 4 vs 3 units) share one stimulus stream.
module tb_ctrl_decode_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, out_ready, err_clr;
    logic [5:0] in_ctrl;
    logic [7:0] in_config;
    logic [3:0] unit_ready;

    logic       a_in_ready, a_out_valid;
    logic [1:0] a_unit, a_op, a_comp, a_err, a_sticky;
    logic [3:0] a_addr;
    logic [2:0] a_size, a_occ;
    logic [7:0] a_cnt;

    logic       b_in_ready, b_out_valid;
    logic [1:0] b_unit, b_op, b_comp, b_err, b_sticky, b_cnt;
    logic [3:0] b_addr;
    logic [2:0] b_size, b_occ;

    ctrl_decode_queue #(.NUM_UNITS(4), .DROP_ERR(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_ctrl(in_ctrl), .in_config(in_config), .unit_ready(unit_ready),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_unit_id(a_unit),
        .out_op(a_op), .out_comp(a_comp), .out_addr(a_addr), .out_size(a_size),
        .out_err(a_err), .err_clr(err_clr), .err_sticky(a_sticky),
        .err_count(a_cnt), .occupancy(a_occ));

    ctrl_decode_queue #(.NUM_UNITS(3), .DROP_ERR(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_ctrl(in_ctrl), .in_config(in_config), .unit_ready(unit_ready[2:0]),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_unit_id(b_unit),
        .out_op(b_op), .out_comp(b_comp), .out_addr(b_addr), .out_size(b_size),
        .out_err(b_err), .err_clr(err_clr), .err_sticky(b_sticky),
        .err_count(b_cnt), .occupancy(b_occ));

    typedef struct packed {
        logic [5:0] ctrl;
        logic [7:0] cfg;
        logic [1:0] u;
        logic [1:0] op;
        logic [1:0] c;
        logic [3:0] a;
        logic [2:0] s;
        logic [1:0] ea;
        logic [1:0] eb;
    } vec_t;

    vec_t        vt [12];
    logic [14:0] qa [$];
    logic [14:0] qb [$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every dispatched head against the scoreboard
    always @(negedge clk) begin
        if (!rst && a_out_valid && out_ready) begin
            if (qa.size() == 0) chk("out_a_unexpected", 32'(1), 32'(0));
            else chk("out_a", 32'({a_unit, a_op, a_comp, a_addr, a_size, a_err}), 32'(qa.pop_front()));
        end
        if (!rst && b_out_valid && out_ready) begin
            if (qb.size() == 0) chk("out_b_unexpected", 32'(1), 32'(0));
            else chk("out_b", 32'({b_unit, b_op, b_comp, b_addr, b_size, b_err}), 32'(qb.pop_front()));
        end
    end

    task automatic send(input int v);
        logic ok;
        ok = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = vt[v].ctrl;
        in_config = vt[v].cfg;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (a_in_ready && b_in_ready) begin
                if (vt[v].ea == 2'b00) qa.push_back({vt[v].u, vt[v].op, vt[v].c, vt[v].a, vt[v].s, vt[v].ea});
                qb.push_back({vt[v].u, vt[v].op, vt[v].c, vt[v].a, vt[v].s, vt[v].eb});
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("send_accept", 32'(ok), 32'(1));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 100 && (qa.size() + qb.size()) != 0; k++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", 32'(qa.size() + qb.size()), 32'(0));
    endtask

    initial begin
        //          ctrl        cfg    u     op    c     a     s     ea     eb
        vt[0]  = '{6'b01_11_10, 8'h5B, 2'd1, 2'd3, 2'd2, 4'h5, 3'd3, 2'b00, 2'b00};
        vt[1]  = '{6'b00_00_00, 8'h01, 2'd0, 2'd0, 2'd0, 4'h0, 3'd1, 2'b01, 2'b01};
        vt[2]  = '{6'b00_01_00, 8'h50, 2'd0, 2'd1, 2'd0, 4'h5, 3'd0, 2'b11, 2'b11};
        vt[3]  = '{6'b11_11_00, 8'h00, 2'd3, 2'd3, 2'd0, 4'h0, 3'd0, 2'b01, 2'b10};
        vt[4]  = '{6'b11_10_00, 8'hF1, 2'd3, 2'd2, 2'd0, 4'hF, 3'd1, 2'b00, 2'b10};
        vt[5]  = '{6'b00_01_01, 8'h1D, 2'd0, 2'd1, 2'd1, 4'h1, 3'd5, 2'b00, 2'b00};
        vt[6]  = '{6'b01_10_11, 8'h2A, 2'd1, 2'd2, 2'd3, 4'h2, 3'd2, 2'b00, 2'b00};
        vt[7]  = '{6'b10_11_00, 8'h38, 2'd2, 2'd3, 2'd0, 4'h3, 3'd0, 2'b00, 2'b00};
        vt[8]  = '{6'b00_00_01, 8'h00, 2'd0, 2'd0, 2'd1, 4'h0, 3'd0, 2'b00, 2'b00};
        vt[9]  = '{6'b10_01_11, 8'hFF, 2'd2, 2'd1, 2'd3, 4'hF, 3'd7, 2'b00, 2'b00};
        vt[10] = '{6'b10_10_10, 8'h47, 2'd2, 2'd2, 2'd2, 4'h4, 3'd7, 2'b00, 2'b00};
        vt[11] = '{6'b00_11_01, 8'h68, 2'd0, 2'd3, 2'd1, 4'h6, 3'd0, 2'b00, 2'b00};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        in_ctrl = 6'd0; in_config = 8'd0; unit_ready = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready_a", 32'(a_in_ready), 32'(0));
        chk("rst_in_ready_b", 32'(b_in_ready), 32'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_occ_a", 32'(a_occ), 32'(0));
        chk("rst_valid_a", 32'(a_out_valid), 32'(0));
        chk("rst_fields_a", 32'({a_unit, a_op, a_comp, a_addr, a_size, a_err}), 32'(0));
        chk("rst_cnt_a", 32'({a_cnt, a_sticky}), 32'(0));
        chk("rdy_after_rst_a", 32'(a_in_ready), 32'(1));
        chk("rdy_after_rst_b", 32'(b_in_ready), 32'(1));

        // Nominal decode and one-cycle latency
        @(posedge clk); #1;
        unit_ready = 4'b0010; out_ready = 1'b1;
        send(0);
        @(negedge clk);
        chk("lat_valid_a", 32'(a_out_valid), 32'(1));
        chk("lat_occ_a", 32'(a_occ), 32'(1));
        @(negedge clk);
        chk("occ_back_0_a", 32'(a_occ), 32'(0));
        chk("occ_back_0_b", 32'(b_occ), 32'(0));

        // Errors: dropped by A, queued and ungated in B
        @(posedge clk); #1;
        send(1);
        @(negedge clk);
        chk("drop_valid_a", 32'(a_out_valid), 32'(0));
        chk("drop_occ_a", 32'(a_occ), 32'(0));
        chk("keep_valid_b", 32'(b_out_valid), 32'(1));
        chk("err1_a", 32'({a_cnt, a_sticky}), 32'({8'd1, 2'b01}));
        chk("err1_b", 32'({b_cnt, b_sticky}), 32'({2'd1, 2'b01}));
        @(posedge clk); #1;
        send(2);
        @(negedge clk);
        chk("err2_a", 32'({a_cnt, a_sticky}), 32'({8'd2, 2'b01}));
        chk("err2_b", 32'({b_cnt, b_sticky}), 32'({2'd2, 2'b01}));

        // Unit range: unit 3 is illegal only in B
        @(posedge clk); #1;
        unit_ready = 4'b1010;
        send(3);
        send(4);
        @(negedge clk);
        chk("err4_a", 32'({a_cnt, a_sticky}), 32'({8'd3, 2'b01}));
        chk("err4_b", 32'({b_cnt, b_sticky}), 32'({2'd3, 2'b01}));
        drain();

        // Clear, clear with coincident error, saturation
        err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        chk("clr_a", 32'({a_cnt, a_sticky}), 32'(0));
        chk("clr_b", 32'({b_cnt, b_sticky}), 32'(0));
        @(posedge clk); #1;
        err_clr = 1'b1;
        send(2);
        err_clr = 1'b0;
        @(negedge clk);
        chk("clr_err_a", 32'({a_cnt, a_sticky}), 32'({8'd1, 2'b11}));
        chk("clr_err_b", 32'({b_cnt, b_sticky}), 32'({2'd1, 2'b11}));
        @(posedge clk); #1;
        send(1); send(2); send(1); send(2);
        @(negedge clk);
        chk("sat_a", 32'({a_cnt, a_sticky}), 32'({8'd5, 2'b11}));
        chk("sat_b", 32'({b_cnt, b_sticky}), 32'({2'd3, 2'b11}));
        drain();

        // Full FIFO and backpressure
        unit_ready = 4'b1111; out_ready = 1'b0;
        send(5); send(6); send(7); send(8);
        @(negedge clk);
        chk("full_occ_a", 32'(a_occ), 32'(4));
        chk("full_occ_b", 32'(b_occ), 32'(4));
        chk("full_rdy_a", 32'(a_in_ready), 32'(0));
        chk("full_rdy_b", 32'(b_in_ready), 32'(0));
        @(posedge clk); #1;
        fork
            send(9);
            begin
                repeat (3) @(negedge clk);
                chk("held_occ_a", 32'(a_occ), 32'(4));
                @(posedge clk); #1 out_ready = 1'b1;
                @(posedge clk); #1 out_ready = 1'b0;
                @(negedge clk);
                chk("pop_occ_a", 32'(a_occ), 32'(3));
                @(negedge clk);
                chk("refill_occ_a", 32'(a_occ), 32'(4));
                chk("refill_occ_b", 32'(b_occ), 32'(4));
            end
        join
        drain();

        // Head-of-line blocking on unit 2
        unit_ready = 4'b1011;
        send(10); send(11);
        repeat (3) @(negedge clk);
        chk("hol_valid_a", 32'(a_out_valid), 32'(0));
        chk("hol_occ_a", 32'(a_occ), 32'(2));
        chk("hol_valid_b", 32'(b_out_valid), 32'(0));
        chk("hol_occ_b", 32'(b_occ), 32'(2));
        @(posedge clk); #1 unit_ready = 4'b1111;
        drain();

        // Reset with entries queued and a packet offered during reset
        out_ready = 1'b0;
        send(5); send(6); send(7);
        @(negedge clk);
        chk("pre_rst_occ_a", 32'(a_occ), 32'(3));
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b1; in_ctrl = vt[5].ctrl; in_config = vt[5].cfg;
        @(negedge clk);
        chk("rst2_rdy_a", 32'(a_in_ready), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        qa.delete(); qb.delete();
        @(negedge clk);
        chk("rst2_occ_a", 32'(a_occ), 32'(0));
        chk("rst2_occ_b", 32'(b_occ), 32'(0));
        chk("rst2_valid_a", 32'(a_out_valid), 32'(0));
        chk("rst2_cnt_a", 32'({a_cnt, a_sticky}), 32'(0));
        chk("rst2_cnt_b", 32'({b_cnt, b_sticky}), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ctrl_decode_queue.md
Name: ctrl_decode_queue

Overview:
Parametrised successor to the single-cycle control decoder. It accepts raw control/config packets over a valid/ready handshake and decodes and error-checks them at entry. Decoded commands are buffered in a DEPTH-entry FIFO and dispatched to target units over a second valid/ready handshake, gated by per-unit readiness. It also keeps sticky error status and a saturating error counter for the host, and sits between the host command interface and the compute-unit array.

Parameters:
NUM_UNITS, 4, number of addressable units; UNIT_W = max(1, $clog2(NUM_UNITS)).
ADDR_W, 4, width of the config address field.
SIZE_W, 3, width of the config size field.
DEPTH, 4, FIFO entries (power of 2, >=2).
CNT_W, 8, error counter width.
DROP_ERR, 1, 1 = errored packets are discarded; 0 = errored packets are queued and emitted with out_err set.

Ports:
clk  in  1  clock.
rst  in  1  reset; synchronous, active-high.
in_valid  in  1  packet valid.
in_ready  out  1  FIFO can accept a packet.
in_ctrl  in  UNIT_W+4  layout: [UNIT_W+3:4] unit_id, [3:2] op, [1:0] comp.
in_config  in  ADDR_W+SIZE_W+1  layout: [top:SIZE_W+1] addr, [SIZE_W] vld, [SIZE_W-1:0] size.
unit_ready  in  NUM_UNITS  per-unit acceptance.
out_valid  out  1  head entry is dispatchable.
out_ready  in  1  consumer accepts the head entry.
out_unit_id  out  UNIT_W  decoded unit.
out_op  out  2  0 NOP, 1 LOAD, 2 STORE, 3 COMPUTE (accel_pkg op encoding).
out_comp  out  2  0 ADD, 1 MUL, 2 TANH, 3 RELU.
out_addr  out  ADDR_W  decoded address.
out_size  out  SIZE_W  decoded size.
out_err  out  2  error code of the head entry.
err_clr  in  1  clears err_sticky and err_count.
err_sticky  out  2  first error code since the last clear.
err_count  out  CNT_W  saturating count of errored packets.
occupancy  out  $clog2(DEPTH)+1  FIFO fill level.

Behaviour:
- Accept condition: in_valid && in_ready; in_ready = (occupancy != DEPTH). There is no bypass when full, even if a pop occurs the same cycle.
- Decode is combinational on the input. The decoded entry and its error code are registered into the FIFO, so the earliest out_valid is the cycle after acceptance.
- Error code priority, highest first:
  - 2'b10: unit_id >= NUM_UNITS.
  - 2'b01: NOP with nonzero config, or COMPUTE with vld=0.
  - 2'b11: LOAD or STORE with size == 0.
  - 2'b00: no error.
- DROP_ERR=1: an accepted errored packet is not written to the FIFO; the error is still recorded.
- DROP_ERR=0: an errored entry is queued. At the head it dispatches without unit_ready gating.
- out_valid = !empty && (out_err != 0 || unit_ready[out_unit_id]). Output fields always show the head entry and are 0 when the FIFO is empty.
- Pop on out_valid && out_ready. Simultaneous push and pop leave occupancy unchanged. Pointers wrap modulo DEPTH.
- Head-of-line blocking: a blocked head stalls all later entries.
- err_count increments by 1 per accepted errored packet and saturates at all-ones.
- err_sticky latches the code of the first error while it is 0, then holds until cleared.
- err_clr in the same cycle as a new error: the result is err_count = 1 and err_sticky = the new code.
- Reset values: occupancy 0, pointers 0, out_valid 0, all out_* fields 0, in_ready 0 during rst (1 from the first cycle after), err_sticky 0, err_count 0.
- Reset mid-operation discards all queued entries; a packet presented during rst is not accepted.
- Non-synthesised simulation check: $display on each errored acceptance.

Test Plan:
- Nominal decode: in_ctrl=6'b01_11_10, in_config=8'h5B, unit_ready=4'b0010, out_ready=1 -> at cycle N+1: out_valid=1, unit 1, COMPUTE, TANH, addr 5, size 3, err 0; occupancy returns to 0 at N+2.
- Error drop/keep: NOP with config 8'h01, DROP_ERR=1 -> out_valid stays 0, err_count=1, err_sticky=01. Same stimulus with DROP_ERR=0 -> one output with out_err=01. LOAD with size 0 -> err 11.
- Unit range: NUM_UNITS=3, unit_id=3 -> err 10, which takes priority over a concurrent config error.
- Full/backpressure: out_ready=0, push 5 packets back-to-back -> in_ready=0 after the 4th, occupancy=4, 5th held. Pulse out_ready for one cycle -> the 5th is accepted on the following cycle, FIFO order preserved.
- Unit gating/HOL: head targets unit 2, unit_ready=4'b1011 -> out_valid=0 and the second entry (unit 0) is blocked. Set bit 2 -> both dispatch in order.
- Counters/reset: CNT_W=2, 5 errors -> err_count=3. err_clr plus a coincident error -> err_count=1. Assert rst with 3 entries queued -> next cycle occupancy=0, out_valid=0, err_count=0.
